// File: rtl/cop_axil_regfile_pkg.sv
// Shared constants, FSM state types and the byte-lane merge helper
// for the coprocessor AXI4-Lite register file.
package cop_axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_OPA  = 2'd1;
    localparam logic [1:0] REG_OPB  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cop_axil_regfile.sv
// AXI4-Lite slave exposing four 32-bit RW registers to the coprocessor core,
// with independent write (AW/W/B) and read (AR/R) state machines.
module cop_axil_regfile
    import cop_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [2:0]                AWPROT,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic [2:0]                ARPROT,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [NUM_REGS*32-1:0]    regs_o,
    output logic [NUM_REGS-1:0]       wr_pulse_o
);

    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]     r_wr_pulse;
    logic                    r_aw_held;
    logic [1:0]              r_aw_idx;
    logic                    r_w_held;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [DATA_WIDTH/8-1:0] r_w_strb;
    logic                    r_bvalid;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_awready;
    logic                    w_wready;
    logic                    w_arready;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic                    w_commit;
    logic                    w_b_done;
    logic [1:0]              w_wr_idx;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [DATA_WIDTH/8-1:0] w_wr_strb;
    logic                    w_unused_bits;

    // Protection bits and the byte offset carry no meaning for this block.
    assign w_unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    assign w_aw_hs   = AWVALID && w_awready;
    assign w_w_hs    = WVALID && w_wready;
    assign w_ar_hs   = ARVALID && w_arready;
    assign w_b_done  = r_bvalid && BREADY;
    assign w_wr_idx  = r_aw_held ? r_aw_idx : AWADDR[3:2];
    assign w_wr_data = r_w_held  ? r_w_data : WDATA;
    assign w_wr_strb = r_w_held  ? r_w_strb : WSTRB;

    // Write FSM next state, ready decode and commit detection.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_awready      = 1'b0;
        w_wready       = 1'b0;
        w_commit       = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                w_awready = !ARESET && !r_aw_held;
                w_wready  = !ARESET && !r_w_held;
                if ((r_aw_held || (AWVALID && w_awready)) &&
                    (r_w_held  || (WVALID  && w_wready))) begin
                    w_commit       = 1'b1;
                    w_wr_state_nxt = WR_RESP;
                end else begin
                    w_wr_state_nxt = WR_IDLE;
                end
            end
            WR_RESP: begin
                if (w_b_done) begin
                    w_wr_state_nxt = WR_IDLE;
                end else begin
                    w_wr_state_nxt = WR_RESP;
                end
            end
            default: begin
                w_wr_state_nxt = WR_IDLE;
            end
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_state <= WR_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    // Capture of whichever of AW/W arrives first; released once B completes.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= 2'd0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else if (w_b_done) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= AWADDR[3:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= WDATA;
                r_w_strb <= WSTRB;
            end
        end
    end

    // Register array, write pulse and write response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_pulse <= '0;
            r_bvalid   <= 1'b0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_regs[w_wr_idx] <= apply_wstrb(r_regs[w_wr_idx], w_wr_data, w_wr_strb);
                r_wr_pulse       <= {{(NUM_REGS-1){1'b0}}, 1'b1} << w_wr_idx;
                r_bvalid         <= 1'b1;
            end else if (w_b_done) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read FSM next state and ready decode.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready      = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                w_arready = !ARESET;
                if (ARVALID && w_arready) begin
                    w_rd_state_nxt = RD_DATA;
                end else begin
                    w_rd_state_nxt = RD_IDLE;
                end
            end
            RD_DATA: begin
                if (RREADY) begin
                    w_rd_state_nxt = RD_IDLE;
                end else begin
                    w_rd_state_nxt = RD_DATA;
                end
            end
            default: begin
                w_rd_state_nxt = RD_IDLE;
            end
        endcase
    end

    // Read FSM state, data and valid; data samples the pre-commit register value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (w_ar_hs) begin
                r_rdata  <= r_regs[ARADDR[3:2]];
                r_rvalid <= 1'b1;
            end else if (r_rvalid && RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_regs_out
            assign regs_o[32*g +: 32] = r_regs[g];
        end
    endgenerate

    assign AWREADY    = w_awready;
    assign WREADY     = w_wready;
    assign ARREADY    = w_arready;
    assign BVALID     = r_bvalid;
    assign BRESP      = AXI_RESP_OKAY;
    assign RVALID     = r_rvalid;
    assign RDATA      = r_rdata;
    assign RRESP      = AXI_RESP_OKAY;
    assign wr_pulse_o = r_wr_pulse;

endmodule
